// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizes for the RAM request controller.
package mem_ctrl_pkg;

   localparam int MEM_DATA_W = 32;
   localparam int MEM_ADDR_W = 5;
   localparam int REQ_DEPTH  = 4;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/mem_ctrl32_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module req_fifo
   import mem_ctrl_pkg::*;
#(
   parameter int DEPTH = REQ_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  req_t din,
   input  logic pop,
   output req_t dout,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   req_t        mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign dout    = mem[rd_ptr[PW-1:0]];
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot the push lands in
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {(PW+1){1'b0}};
         rd_ptr <= {(PW+1){1'b0}};
      end else begin
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push)
            wr_ptr <= wr_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/mem_ctrl32.sv
// Single-port RAM controller: zero-fills the RAM after reset, then issues queued
// read/write requests in order and returns read data two cycles after acceptance.
module mem_ctrl32
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = REQ_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              init_done,
   output logic              mem_r_w,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_d_in,
   input  logic [DATA_W-1:0] mem_d_out
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t state;
   logic   fifo_full;
   logic   fifo_empty;
   logic   push;
   logic   pop;
   logic   rd_issued;
   req_t   push_req;
   req_t   head;

   assign req_ready = (state == RUN) && !fifo_full;
   assign push      = req_valid && req_ready;
   assign pop       = (state == RUN) && !fifo_empty;
   assign push_req  = '{we: req_we, addr: req_addr, wdata: req_wdata};

   req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_req),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // mem_addr doubles as the zero-fill counter while in INIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         init_done <= 1'b0;
         mem_r_w   <= 1'b1;
         mem_addr  <= {ADDR_W{1'b0}};
         mem_d_in  <= {DATA_W{1'b0}};
         rd_issued <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= {DATA_W{1'b0}};
      end else begin
         rsp_valid <= rd_issued;
         if (rd_issued)
            rsp_rdata <= mem_d_out;
         rd_issued <= 1'b0;
         case (state)
            INIT: begin
               if (mem_addr == LAST_ADDR) begin
                  state     <= RUN;
                  init_done <= 1'b1;
                  mem_r_w   <= 1'b0;
               end else begin
                  mem_addr  <= mem_addr + ADDR_ONE;
               end
            end
            RUN: begin
               if (!fifo_empty) begin
                  mem_r_w   <= head.we;
                  mem_addr  <= head.addr;
                  mem_d_in  <= head.wdata;
                  rd_issued <= !head.we;
               end else begin
                  mem_r_w   <= 1'b0;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl32.sv
// Directed and table-driven bench for mem_ctrl32 with a behavioural 32x32 RAM beside it.
module tb_mem_ctrl32;
   import mem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        init_done;
   logic        mem_r_w;
   logic [4:0]  mem_addr;
   logic [31:0] mem_d_in;
   logic [31:0] mem_d_out;

   logic [31:0] ram [32];
   logic [31:0] shadow [32];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] data;
      int          at;
   } exp_t;
   exp_t expq[$];

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[8];

   mem_ctrl32 dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .init_done (init_done),
      .mem_r_w   (mem_r_w),
      .mem_addr  (mem_addr),
      .mem_d_in  (mem_d_in),
      .mem_d_out (mem_d_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_r_w)
         ram[mem_addr] <= mem_d_in;
   end
   assign mem_d_out = ram[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // every response must match the oldest outstanding read, on its due cycle
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid === 1'b1) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 data %h expected no response (cycle %0d)", rsp_rdata, cyc);
         end else begin
            e = expq.pop_front();
            check("rsp_data", rsp_rdata, e.data);
            check("rsp_cycle", cyc, e.at);
         end
      end
   end

   task automatic send(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, output int waited);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      waited    = 0;
      while (req_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (req_ready !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got req_ready=%b expected 1 within 100 cycles", req_ready);
         req_valid = 1'b0;
         return;
      end
      if (!we)
         expq.push_back('{exp, cyc + 3});
      else
         shadow[addr] = wdata;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_shadow();
      for (int i = 0; i < 32; i++)
         shadow[i] = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [4:0]  ra;
      logic [31:0] rd;
      logic        rw;

      vecs[0] = '{1'b1, 5'd0,  32'h00adc462, 32'h0};
      vecs[1] = '{1'b1, 5'd15, 32'h004da65c, 32'h0};
      vecs[2] = '{1'b1, 5'd5,  32'h00fa537c, 32'h0};
      vecs[3] = '{1'b0, 5'd15, 32'h0,        32'h004da65c};
      vecs[4] = '{1'b0, 5'd1,  32'h0,        32'h0};
      vecs[5] = '{1'b0, 5'd5,  32'h0,        32'h00fa537c};
      vecs[6] = '{1'b1, 5'd7,  32'h12345678, 32'h0};
      vecs[7] = '{1'b0, 5'd7,  32'h0,        32'h12345678};

      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = 5'd0;
      req_wdata = 32'h0;
      clear_shadow();
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_init_done", init_done, 0);
      check("rst_mem_r_w", mem_r_w, 1);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_d_in", mem_d_in, 0);

      // zero-fill walk: edge i writes address i-1, done after edge 32
      rst = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         check("init_done", init_done, i == 32);
         check("init_req_ready", req_ready, i == 32);
         check("init_mem_r_w", mem_r_w, i != 32);
         check("init_mem_addr", mem_addr, (i == 32) ? 31 : i);
      end

      for (int a = 0; a < 32; a++)
         send(1'b0, 5'(a), 32'h0, 32'h0, w);
      idle(4);
      check("drain_zero_reads", expq.size(), 0);

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, w);
         check("vec_throughput", w, 0);
      end
      idle(4);
      check("drain_vectors", expq.size(), 0);

      send(1'b1, 5'd9, 32'hcafe0009, 32'h0, w);
      req_valid = 1'b0;
      @(negedge clk);
      check("wr_issue_r_w", mem_r_w, 1);
      check("wr_issue_addr", mem_addr, 9);
      check("wr_issue_d_in", mem_d_in, 32'hcafe0009);
      @(negedge clk);
      check("idle_r_w", mem_r_w, 0);
      check("idle_addr_hold", mem_addr, 9);
      check("idle_d_in_hold", mem_d_in, 32'hcafe0009);
      check("ram_written", ram[9], 32'hcafe0009);
      send(1'b0, 5'd9, 32'h0, 32'hcafe0009, w);
      idle(4);
      check("drain_wr_port", expq.size(), 0);

      // request held through a fresh init, then a random stream at full rate
      rst = 1'b1;
      req_valid = 1'b0;
      expq.delete();
      repeat (2) @(negedge clk);
      clear_shadow();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rw = 1'($urandom_range(0, 1));
         ra = 5'($urandom_range(0, 31));
         rd = $urandom;
         send(rw, ra, rd, shadow[ra], w);
         check("bp_wait", w, (i == 0) ? 32 : 0);
      end
      idle(4);
      check("drain_random", expq.size(), 0);
      for (int a = 0; a < 32; a++)
         send(1'b0, 5'(a), 32'h0, shadow[a], w);
      idle(4);
      check("drain_readback", expq.size(), 0);

      // reset with reads in flight: nothing may come out until new requests arrive
      send(1'b1, 5'd3, 32'h55aa55aa, 32'h0, w);
      send(1'b0, 5'd3, 32'h0, 32'h55aa55aa, w);
      send(1'b0, 5'd3, 32'h0, 32'h55aa55aa, w);
      send(1'b0, 5'd3, 32'h0, 32'h55aa55aa, w);
      #2;
      rst = 1'b1;
      req_valid = 1'b0;
      expq.delete();
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_rsp_valid", rsp_valid, 0);
         check("mid_rst_init_done", init_done, 0);
         check("mid_rst_mem_addr", mem_addr, 0);
      end
      clear_shadow();
      rst = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         check("reinit_rsp_valid", rsp_valid, 0);
         check("reinit_done", init_done, i == 32);
      end
      send(1'b0, 5'd3, 32'h0, 32'h0, w);
      send(1'b0, 5'd9, 32'h0, 32'h0, w);
      idle(4);
      check("drain_after_reset", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
